memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 127 ++++++++++++
 tb/tb_memory_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Dual-port memory responder: zero-latency fetch and load ports over a word array,
// fronted by a small coalescing write buffer that drains its oldest entry into the array.
module memory_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int WB_DEPTH  = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 readM1,
  input  logic [WORD_SIZE-1:0] address1,
  output logic [WORD_SIZE-1:0] data1,
  input  logic                 readM2,
  input  logic                 writeM2,
  input  logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2,
  output logic [WORD_SIZE-1:0] num_reads,
  output logic [WORD_SIZE-1:0] num_writes,
  output logic [2:0]           wb_count
);

  localparam int         DEPTH   = 1 << ADDR_BITS;
  localparam logic [2:0] WB_FULL = 3'(WB_DEPTH);

  logic [WORD_SIZE-1:0] mem_reg     [DEPTH];
  logic [ADDR_BITS-1:0] wb_addr_reg [WB_DEPTH];
  logic [WORD_SIZE-1:0] wb_data_reg [WB_DEPTH];
  logic [ADDR_BITS-1:0] wb_addr_next[WB_DEPTH];
  logic [WORD_SIZE-1:0] wb_data_next[WB_DEPTH];
  logic [WORD_SIZE-1:0] fwd1_mask   [WB_DEPTH];
  logic [WORD_SIZE-1:0] fwd2_mask   [WB_DEPTH];

  logic [2:0]           count_reg, count_next, tail_slot;
  logic [WORD_SIZE-1:0] reads_reg, writes_reg;
  logic [ADDR_BITS-1:0] idx1, idx2;
  logic [WB_DEPTH-1:0]  hit1, hit2;
  logic [WORD_SIZE-1:0] fwd1, fwd2, rd1, rd2;
  logic                 store, drain, any_hit2, head_coalesce, load2;
  logic                 unused_addr_bits;

  assign idx1             = address1[ADDR_BITS-1:0];
  assign idx2             = address2[ADDR_BITS-1:0];
  assign unused_addr_bits = ^{address1[WORD_SIZE-1:ADDR_BITS], address2[WORD_SIZE-1:ADDR_BITS]};

  assign store         = writeM2;
  assign load2         = readM2 && !writeM2;
  assign drain         = (count_reg != 3'd0) && (!readM1 || count_reg == WB_FULL);
  assign any_hit2      = |hit2;
  assign head_coalesce = store && drain && hit2[0];
  assign tail_slot     = drain ? count_reg - 3'd1 : count_reg;
  assign count_next    = count_reg + ((store && !any_hit2) ? 3'd1 : 3'd0) - (drain ? 3'd1 : 3'd0);

  // Entry 0 is always the oldest; a drain shifts every entry down by one slot.
  for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_entry
    logic [ADDR_BITS-1:0] src_addr;
    logic [WORD_SIZE-1:0] src_data;
    logic                 src_hit;
    logic                 append;

    // Reads ignore the buffer while reset is held, so they see the array only.
    assign hit1[gi] = Reset_N && (3'(gi) < count_reg) && (wb_addr_reg[gi] == idx1);
    assign hit2[gi] = Reset_N && (3'(gi) < count_reg) && (wb_addr_reg[gi] == idx2);
    assign fwd1_mask[gi] = hit1[gi] ? wb_data_reg[gi] : '0;
    assign fwd2_mask[gi] = hit2[gi] ? wb_data_reg[gi] : '0;

    if (gi < WB_DEPTH - 1) begin : g_shift
      assign src_addr = drain ? wb_addr_reg[gi+1] : wb_addr_reg[gi];
      assign src_data = drain ? wb_data_reg[gi+1] : wb_data_reg[gi];
      assign src_hit  = drain ? hit2[gi+1]        : hit2[gi];
    end else begin : g_last
      assign src_addr = wb_addr_reg[gi];
      assign src_data = wb_data_reg[gi];
      assign src_hit  = drain ? 1'b0 : hit2[gi];
    end

    assign append           = store && !any_hit2 && (tail_slot == 3'(gi));
    assign wb_addr_next[gi] = append ? idx2 : src_addr;
    assign wb_data_next[gi] = ((store && src_hit) || append) ? data2 : src_data;
  end

  // At most one entry can match a given index, so OR-ing the masked entries selects it.
  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      fwd1 = fwd1 | fwd1_mask[i];
      fwd2 = fwd2 | fwd2_mask[i];
    end
  end

  assign rd1 = (|hit1) ? fwd1 : mem_reg[idx1];
  assign rd2 = (|hit2) ? fwd2 : mem_reg[idx2];

  assign data1      = readM1 ? rd1 : '0;
  assign data2      = load2 ? rd2 : {WORD_SIZE{1'bz}};
  assign num_reads  = reads_reg;
  assign num_writes = writes_reg;
  assign wb_count   = count_reg;

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      count_reg  <= 3'd0;
      reads_reg  <= '0;
      writes_reg <= '0;
    end else begin
      count_reg  <= count_next;
      reads_reg  <= reads_reg + WORD_SIZE'(readM1) + WORD_SIZE'(load2);
      writes_reg <= writes_reg + WORD_SIZE'(store);
    end
  end

  // Entries past the occupancy are don't-care, so the payload needs no reset.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < WB_DEPTH; i++) begin
      wb_addr_reg[i] <= wb_addr_next[i];
      wb_data_reg[i] <= wb_data_next[i];
    end
  end

  // A store coalescing onto the retiring head goes straight to the array.
  always_ff @(posedge Clk) begin
    if (Reset_N && drain) begin
      mem_reg[wb_addr_reg[0]] <= head_coalesce ? data2 : wb_data_reg[0];
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: forwarding, coalescing, forced/opportunistic drain,
// reset behaviour and the read+write collision on the load/store port.
module tb_memory_responder;

  logic        Clk = 1'b0;
  logic        Reset_N, readM1, readM2, writeM2;
  logic [15:0] address1, address2, data1, num_reads, num_writes;
  logic [2:0]  wb_count;
  wire  [15:0] data2;
  logic        cpu_en;
  logic [15:0] cpu_data;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_reads  = 16'd0;
  logic [15:0] exp_writes = 16'd0;
  logic [15:0] snap;

  always #5 Clk = ~Clk;

  assign data2 = cpu_en ? cpu_data : 16'hzzzz;

  memory_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .WB_DEPTH(4)) dut (
    .Clk        (Clk),
    .Reset_N    (Reset_N),
    .readM1     (readM1),
    .address1   (address1),
    .data1      (data1),
    .readM2     (readM2),
    .writeM2    (writeM2),
    .address2   (address2),
    .data2      (data2),
    .num_reads  (num_reads),
    .num_writes (num_writes),
    .wb_count   (wb_count)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // One clock: the counter model follows the inputs held across this edge.
  task automatic cyc();
    if (!Reset_N) begin
      exp_reads  = 16'd0;
      exp_writes = 16'd0;
    end else begin
      exp_reads  = exp_reads + {15'd0, readM1} + {15'd0, readM2 && !writeM2};
      exp_writes = exp_writes + {15'd0, writeM2};
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d, input logic r1);
    readM1   = r1;
    readM2   = 1'b0;
    writeM2  = 1'b1;
    address2 = a;
    cpu_en   = 1'b1;
    cpu_data = d;
    cyc();
    writeM2  = 1'b0;
    cpu_en   = 1'b0;
  endtask

  task automatic idle(input logic r1);
    readM1  = r1;
    readM2  = 1'b0;
    writeM2 = 1'b0;
    cpu_en  = 1'b0;
    cyc();
  endtask

  // Combinational load on port 2; no clock edge is taken.
  task automatic load_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    writeM2  = 1'b0;
    cpu_en   = 1'b0;
    readM2   = 1'b1;
    address2 = a;
    #1;
    check_val(tag, data2, exp);
    readM2 = 1'b0;
  endtask

  initial begin
    Reset_N  = 1'b0;
    readM1   = 1'b0;
    readM2   = 1'b0;
    writeM2  = 1'b0;
    address1 = 16'd0;
    address2 = 16'd0;
    cpu_en   = 1'b0;
    cpu_data = 16'd0;
    cyc();
    cyc();
    check_val("rst_wb_count", {13'd0, wb_count}, 16'd0);
    check_val("rst_num_reads", num_reads, 16'd0);
    check_val("rst_num_writes", num_writes, 16'd0);
    Reset_N = 1'b1;

    // Seed known array contents through opportunistic drains.
    store(16'h0005, 16'h0555, 1'b0); idle(1'b0);
    store(16'h0030, 16'h3000, 1'b0); idle(1'b0);
    store(16'h0031, 16'h3100, 1'b0); idle(1'b0);
    store(16'h0060, 16'hF00F, 1'b0); idle(1'b0);
    check_val("seed_wb_count", {13'd0, wb_count}, 16'd0);
    check_val("seed_mem5", dut.mem_reg[5], 16'h0555);
    load_chk("seed_load5", 16'h0005, 16'h0555);
    check_val("seed_num_writes", num_writes, 16'd4);
    check_val("seed_num_reads", num_reads, 16'd0);
    check_val("data1_idle_zero", data1, 16'd0);

    // Store forwarded before it reaches the array.
    readM1 = 1'b1; address1 = 16'h0005; #1;
    check_val("fetch5_before", data1, 16'h0555);
    store(16'h0005, 16'h1234, 1'b1);
    check_val("fwd_wb_count", {13'd0, wb_count}, 16'd1);
    load_chk("fwd_load5", 16'h0005, 16'h1234);
    load_chk("fwd_load_hiaddr", 16'hFF05, 16'h1234);
    check_val("fwd_fetch5", data1, 16'h1234);
    check_val("fwd_mem5_old", dut.mem_reg[5], 16'h0555);
    readM1 = 1'b0; #1;
    check_val("fetch_off_zero", data1, 16'd0);
    idle(1'b0);
    check_val("drain5_wb_count", {13'd0, wb_count}, 16'd0);
    check_val("drain5_mem5", dut.mem_reg[5], 16'h1234);

    // Five distinct stores: the fifth forces the head out while appending.
    for (int i = 0; i < 5; i++) begin
      store(16'h0010 + 16'(i), 16'hA010 + 16'(i), 1'b1);
      check_val($sformatf("fill_wb_count_%0d", i), {13'd0, wb_count}, (i < 4) ? 16'(i + 1) : 16'd4);
    end
    check_val("fill_mem10", dut.mem_reg[16'h10], 16'hA010);
    for (int i = 0; i < 5; i++) begin
      load_chk($sformatf("fill_load_%0d", i), 16'h0010 + 16'(i), 16'hA010 + 16'(i));
    end
    address1 = 16'h0014; #1;
    check_val("fill_fetch14", data1, 16'hA014);
    repeat (4) idle(1'b0);
    check_val("fill_drained", {13'd0, wb_count}, 16'd0);

    // Coalescing two stores to one address.
    snap = num_writes;
    store(16'h0020, 16'hAAAA, 1'b1);
    store(16'h0020, 16'hBBBB, 1'b1);
    check_val("coal_wb_count", {13'd0, wb_count}, 16'd1);
    load_chk("coal_load20", 16'h0020, 16'hBBBB);
    check_val("coal_nw_delta", num_writes - snap, 16'd2);
    check_val("coal_num_writes", num_writes, exp_writes);
    idle(1'b0);

    // Full buffer, store coalescing onto the draining head.
    for (int i = 0; i < 4; i++) store(16'h0040 + 16'(i), 16'h4000 + 16'(i), 1'b1);
    check_val("head_full", {13'd0, wb_count}, 16'd4);
    store(16'h0040, 16'h4444, 1'b1);
    check_val("head_wb_count", {13'd0, wb_count}, 16'd3);
    check_val("head_mem40", dut.mem_reg[16'h40], 16'h4444);
    load_chk("head_load40", 16'h0040, 16'h4444);
    store(16'h0042, 16'h4242, 1'b0);
    check_val("mid_wb_count", {13'd0, wb_count}, 16'd2);
    check_val("mid_mem41", dut.mem_reg[16'h41], 16'h4001);
    load_chk("mid_load42", 16'h0042, 16'h4242);
    load_chk("mid_load43", 16'h0043, 16'h4003);
    idle(1'b0); idle(1'b0);
    check_val("mid_mem42", dut.mem_reg[16'h42], 16'h4242);
    check_val("mid_mem43", dut.mem_reg[16'h43], 16'h4003);

    // Opportunistic drain in FIFO order.
    for (int i = 0; i < 3; i++) store(16'h0050 + 16'(i), 16'h5000 + 16'(i), 1'b1);
    check_val("fifo_wb_count", {13'd0, wb_count}, 16'd3);
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      check_val($sformatf("fifo_wb_%0d", k), {13'd0, wb_count}, 16'(2 - k));
      check_val($sformatf("fifo_mem_%0d", k), dut.mem_reg[16'h50 + k], 16'h5000 + 16'(k));
    end

    // Reset discards pending stores and beats a concurrent store.
    store(16'h0030, 16'h3333, 1'b1);
    store(16'h0031, 16'h3434, 1'b1);
    check_val("prerst_wb_count", {13'd0, wb_count}, 16'd2);
    Reset_N = 1'b0;
    readM1 = 1'b1; address1 = 16'h0031;
    load_chk("inrst_load30", 16'h0030, 16'h3000);
    check_val("inrst_fetch31", data1, 16'h3100);
    writeM2 = 1'b1; address2 = 16'h0030; cpu_en = 1'b1; cpu_data = 16'h9999;
    cyc();
    writeM2 = 1'b0; cpu_en = 1'b0; Reset_N = 1'b1;
    check_val("postrst_wb_count", {13'd0, wb_count}, 16'd0);
    check_val("postrst_num_reads", num_reads, 16'd0);
    check_val("postrst_num_writes", num_writes, 16'd0);
    check_val("postrst_mem30", dut.mem_reg[16'h30], 16'h3000);
    load_chk("postrst_load30", 16'h0030, 16'h3000);
    load_chk("postrst_load31", 16'h0031, 16'h3100);
    idle(1'b1);
    check_val("postrst_reads1", num_reads, 16'd1);

    // Read+write together is a store only; the CPU owns data2.
    snap = num_reads;
    readM1 = 1'b1; readM2 = 1'b1; writeM2 = 1'b1;
    address2 = 16'h0060; cpu_en = 1'b1; cpu_data = 16'h00FF;
    #1;
    check_val("rw_data2_cpu", data2, 16'h00FF);
    cyc();
    readM2 = 1'b0; writeM2 = 1'b0; cpu_en = 1'b0;
    check_val("rw_reads_delta", num_reads - snap, 16'd1);
    check_val("rw_num_reads", num_reads, exp_reads);
    check_val("rw_num_writes", num_writes, 16'd1);
    check_val("rw_wb_count", {13'd0, wb_count}, 16'd1);
    load_chk("rw_load60", 16'h0060, 16'h00FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
